// File: rtl/pacman_pkg.sv
// ============================================================================
// Module  : pacman_pkg
// Brief   : Shared constants and state encoding for the BCD conversion engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pacman_pkg;

  localparam int BCD_WIDTH = 9;
  localparam int DIGIT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_dd_step.sv
// ============================================================================
// Module  : bcd_dd_step
// Brief   : One double-dabble iteration: add-3 on digits >= 5, then shift in a bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dd_step
  import pacman_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_hundreds,
  input  logic [DIGIT_W-1:0] i_tens,
  input  logic [DIGIT_W-1:0] i_ones,
  input  logic               i_bit,
  output logic [DIGIT_W-1:0] o_hundreds,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones
);

  // The adjusted hundreds MSB is shifted out and lost, so only its low bits are kept.
  logic [2:0]         w_h_adj;
  logic [DIGIT_W-1:0] w_t_adj;
  logic [DIGIT_W-1:0] w_o_adj;

  assign w_h_adj = (i_hundreds >= DIGIT_W'(5)) ? (i_hundreds[2:0] + 3'd3) : i_hundreds[2:0];
  assign w_t_adj = (i_tens     >= DIGIT_W'(5)) ? (i_tens + DIGIT_W'(3))   : i_tens;
  assign w_o_adj = (i_ones     >= DIGIT_W'(5)) ? (i_ones + DIGIT_W'(3))   : i_ones;

  assign o_hundreds = {w_h_adj, w_t_adj[3]};
  assign o_tens     = {w_t_adj[2:0], w_o_adj[3]};
  assign o_ones     = {w_o_adj[2:0], i_bit};

endmodule

`default_nettype wire

// File: rtl/bcd_convert_scheduler.sv
// ============================================================================
// Module  : bcd_convert_scheduler
// Brief   : Round-robin shared serial binary-to-BCD converter for display requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_convert_scheduler
  import pacman_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = BCD_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     bin_in,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic                      out_valid,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic [DIGIT_W-1:0]        hundreds,
  output logic [DIGIT_W-1:0]        tens,
  output logic [DIGIT_W-1:0]        ones
);

  localparam int              c_idw      = $clog2(NREQ);
  localparam int              c_cw       = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [DIGIT_W-1:0] r_hund;
  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;
  logic [c_cw-1:0]    r_cnt;
  logic [c_idw-1:0]   r_cur_id;
  logic [c_idw-1:0]   r_last_id;

  logic               w_grant_vld;
  logic [c_idw-1:0]   w_grant_id;
  logic [WIDTH-1:0]   w_operand;
  logic [NREQ-1:0]    w_ack_nxt;
  logic [DIGIT_W-1:0] w_step_h;
  logic [DIGIT_W-1:0] w_step_t;
  logic [DIGIT_W-1:0] w_step_o;

  // Rotating priority: walk offsets from farthest to nearest so the requester
  // closest after last_id is the one left standing.
  always_comb begin
    int k;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    k           = 0;
    for (int i = NREQ; i >= 1; i--) begin
      k = int'(r_last_id) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = c_idw'(k);
      end
    end
  end

  always_comb begin
    w_operand = '0;
    w_ack_nxt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (c_idw'(k) == w_grant_id) begin
        w_operand    = bin_in[k*WIDTH +: WIDTH];
        w_ack_nxt[k] = w_grant_vld;
      end
    end
  end

  bcd_dd_step u_step (
    .i_hundreds (r_hund),
    .i_tens     (r_tens),
    .i_ones     (r_ones),
    .i_bit      (r_shift[WIDTH-1]),
    .o_hundreds (w_step_h),
    .o_tens     (w_step_t),
    .o_ones     (w_step_o)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:  if (w_grant_vld) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The final iteration's result is loaded straight into the output digits so
  // they are already valid during the DONE cycle alongside out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_hund    <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_cnt     <= '0;
      r_cur_id  <= '0;
      r_last_id <= c_idw'(NREQ - 1);
      ack       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      ack       <= '0;
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_shift  <= w_operand;
            r_cur_id <= w_grant_id;
            r_hund   <= '0;
            r_tens   <= '0;
            r_ones   <= '0;
            r_cnt    <= c_cnt_init;
            ack      <= w_ack_nxt;
          end
        end
        ST_SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_hund  <= w_step_h;
          r_tens  <= w_step_t;
          r_ones  <= w_step_o;
          r_cnt   <= r_cnt - c_cw'(1);
          if (r_cnt == '0) begin
            hundreds  <= w_step_h;
            tens      <= w_step_t;
            ones      <= w_step_o;
            out_id    <= r_cur_id;
            out_valid <= 1'b1;
            r_last_id <= r_cur_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
